// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- decode stage of a 5-stage MIPS pipeline.
//
// Takes the IF/ID register contents, reads the 32-entry register file,
// decodes control and loads the ID/EX pipeline register. It also tells fetch
// about jumps and beq, and holds fetch for one cycle on a load-use hazard.
//
// Ports
//   clk, ID_rst                     clock, synchronous active-high reset
//   IF_ID_*                         instruction, pc+4, BTB target, 2-bit counter
//   EX_ID_flush                     kill the instruction currently in ID
//   WB_ID_reg_write/write_reg/data  register-file write port
//   ID_IF_jump / _jump_target       j decoded (suppressed while stalled)
//   ID_IF_branch                    beq in ID (independent of stall)
//   pc_enable, IF_enable            low for the single load-use stall cycle
//   ID_EX_*                         registered operands, fields and control
//
// Handshake: there is no valid/ready pair. The instruction in IF/ID is
// accepted on every rising edge unless pc_enable/IF_enable are low, in which
// case IF/ID holds it and ID re-decodes it on the following cycle.
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              ID_rst,
    input  logic [31:0]       IF_ID_instruction,
    input  logic [31:0]       IF_ID_pc,
    input  logic [31:0]       IF_ID_branch_target_predict,
    input  logic [1:0]        IF_ID_predictor,
    input  logic              EX_ID_flush,
    input  logic              WB_ID_reg_write,
    input  logic [REG_AW-1:0] WB_ID_write_reg,
    input  logic [DATA_W-1:0] WB_ID_write_data,
    output logic              ID_IF_jump,
    output logic [31:0]       ID_IF_jump_target,
    output logic              ID_IF_branch,
    output logic              pc_enable,
    output logic              IF_enable,
    output logic [DATA_W-1:0] ID_EX_rs_data,
    output logic [DATA_W-1:0] ID_EX_rt_data,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic [REG_AW-1:0] ID_EX_rs,
    output logic [REG_AW-1:0] ID_EX_rt,
    output logic [REG_AW-1:0] ID_EX_rd,
    output logic [31:0]       ID_EX_pc,
    output logic [31:0]       ID_EX_branch_target_predict,
    output logic [1:0]        ID_EX_predictor,
    output logic [2:0]        ID_EX_alu_op,
    output logic              ID_EX_reg_write,
    output logic              ID_EX_mem_read,
    output logic              ID_EX_mem_write,
    output logic              ID_EX_mem_to_reg,
    output logic              ID_EX_alu_src,
    output logic              ID_EX_reg_dst,
    output logic              ID_EX_branch
);

    localparam int  NREG   = 1 << REG_AW;
    localparam bit  LU_EN  = (LU_STALL != 0);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;

    assign op    = IF_ID_instruction[31:26];
    assign funct = IF_ID_instruction[5:0];
    assign rs    = IF_ID_instruction[21 +: REG_AW];
    assign rt    = IF_ID_instruction[16 +: REG_AW];
    assign rd    = IF_ID_instruction[11 +: REG_AW];

    // ------------------------------------------------------------------
    // Control decode. Anything not recognised decodes as a bubble.
    // ------------------------------------------------------------------
    logic       c_reg_write, c_mem_read, c_mem_write, c_mem_to_reg;
    logic       c_alu_src, c_reg_dst, c_branch;
    logic [2:0] c_alu_op;

    always_comb begin
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_mem_to_reg = 1'b0;
        c_alu_src    = 1'b0;
        c_reg_dst    = 1'b0;
        c_branch     = 1'b0;
        c_alu_op     = 3'd0;
        case (op)
            OP_R: begin
                case (funct)
                    6'h20: begin c_reg_write = 1'b1; c_reg_dst = 1'b1; c_alu_op = 3'd0; end
                    6'h22: begin c_reg_write = 1'b1; c_reg_dst = 1'b1; c_alu_op = 3'd1; end
                    6'h24: begin c_reg_write = 1'b1; c_reg_dst = 1'b1; c_alu_op = 3'd2; end
                    6'h25: begin c_reg_write = 1'b1; c_reg_dst = 1'b1; c_alu_op = 3'd3; end
                    6'h2A: begin c_reg_write = 1'b1; c_reg_dst = 1'b1; c_alu_op = 3'd4; end
                    default: ;
                endcase
            end
            OP_LW: begin
                c_mem_read   = 1'b1;
                c_mem_to_reg = 1'b1;
                c_alu_src    = 1'b1;
                c_reg_write  = 1'b1;
            end
            OP_SW: begin
                c_mem_write = 1'b1;
                c_alu_src   = 1'b1;
            end
            OP_BEQ: begin
                c_branch = 1'b1;
                c_alu_op = 3'd1;
            end
            OP_ADDI: begin
                c_alu_src   = 1'b1;
                c_reg_write = 1'b1;
            end
            default: ;  // j and unknown opcodes carry no control
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use hazard. rt only counts as a source for R-type, sw and beq;
    // for lw/addi it is the destination.
    // ------------------------------------------------------------------
    logic rt_is_src;
    logic stall;

    assign rt_is_src = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
    assign stall     = LU_EN && ID_EX_mem_read && (ID_EX_rt != '0) &&
                       ((ID_EX_rt == rs) || ((ID_EX_rt == rt) && rt_is_src));

    assign pc_enable         = ~stall;
    assign IF_enable         = ~stall;
    assign ID_IF_jump        = (op == OP_J) && ~stall;
    assign ID_IF_jump_target = {IF_ID_pc[31:28], IF_ID_instruction[25:0], 2'b00};
    assign ID_IF_branch      = (op == OP_BEQ);

    // ------------------------------------------------------------------
    // Register file with write-through reads so a WB in the same cycle is
    // seen without an extra bypass stage.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              wb_live;

    assign wb_live = WB_ID_reg_write && (WB_ID_write_reg != '0);

    always_ff @(posedge clk) begin
        if (ID_rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_live) begin
            regs[WB_ID_write_reg] <= WB_ID_write_data;
        end
    end

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != '0) rs_val = (wb_live && WB_ID_write_reg == rs) ? WB_ID_write_data : regs[rs];
        if (rt != '0) rt_val = (wb_live && WB_ID_write_reg == rt) ? WB_ID_write_data : regs[rt];
    end

    // ------------------------------------------------------------------
    // ID/EX register. Reset, flush and stall all load the same bubble,
    // so they share one branch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ID_rst || EX_ID_flush || stall) begin
            ID_EX_rs_data               <= '0;
            ID_EX_rt_data               <= '0;
            ID_EX_imm                   <= '0;
            ID_EX_rs                    <= '0;
            ID_EX_rt                    <= '0;
            ID_EX_rd                    <= '0;
            ID_EX_pc                    <= '0;
            ID_EX_branch_target_predict <= 32'd1;
            ID_EX_predictor             <= 2'b01;
            ID_EX_alu_op                <= 3'd0;
            ID_EX_reg_write             <= 1'b0;
            ID_EX_mem_read              <= 1'b0;
            ID_EX_mem_write             <= 1'b0;
            ID_EX_mem_to_reg            <= 1'b0;
            ID_EX_alu_src               <= 1'b0;
            ID_EX_reg_dst               <= 1'b0;
            ID_EX_branch                <= 1'b0;
        end else begin
            ID_EX_rs_data               <= rs_val;
            ID_EX_rt_data               <= rt_val;
            ID_EX_imm                   <= {{(DATA_W-16){IF_ID_instruction[15]}}, IF_ID_instruction[15:0]};
            ID_EX_rs                    <= rs;
            ID_EX_rt                    <= rt;
            ID_EX_rd                    <= rd;
            ID_EX_pc                    <= IF_ID_pc;
            ID_EX_branch_target_predict <= IF_ID_branch_target_predict;
            ID_EX_predictor             <= IF_ID_predictor;
            ID_EX_alu_op                <= c_alu_op;
            ID_EX_reg_write             <= c_reg_write;
            ID_EX_mem_read              <= c_mem_read;
            ID_EX_mem_write             <= c_mem_write;
            ID_EX_mem_to_reg            <= c_mem_to_reg;
            ID_EX_alu_src               <= c_alu_src;
            ID_EX_reg_dst               <= c_reg_dst;
            ID_EX_branch                <= c_branch;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- directed bench for id_stage. Each step drives IF/ID and WB
// inputs, pushes the expected ID/EX contents, checks the combinational fetch
// outputs mid-cycle, then pops and compares ID/EX after the rising edge.
// -----------------------------------------------------------------------------
module tb_id_stage;

    localparam int VW = 187;

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_R    = 7'b1000010;
    localparam logic [6:0] C_LW   = 7'b1101100;
    localparam logic [6:0] C_SW   = 7'b0010100;
    localparam logic [6:0] C_BEQ  = 7'b0000001;
    localparam logic [6:0] C_ADDI = 7'b1000100;

    localparam logic [VW-1:0] FULL   = {VW{1'b1}};
    localparam logic [VW-1:0] CTRL_M = {10'h3FF, {(VW-10){1'b0}}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ID_rst;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_branch_target_predict;
    logic [1:0]  IF_ID_predictor;
    logic        EX_ID_flush;
    logic        WB_ID_reg_write;
    logic [4:0]  WB_ID_write_reg;
    logic [31:0] WB_ID_write_data;
    logic        ID_IF_jump;
    logic [31:0] ID_IF_jump_target;
    logic        ID_IF_branch;
    logic        pc_enable;
    logic        IF_enable;
    logic [31:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_rd;
    logic [31:0] ID_EX_pc, ID_EX_branch_target_predict;
    logic [1:0]  ID_EX_predictor;
    logic [2:0]  ID_EX_alu_op;
    logic        ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg;
    logic        ID_EX_alu_src, ID_EX_reg_dst, ID_EX_branch;

    id_stage #(.DATA_W(32), .REG_AW(5), .LU_STALL(1)) dut (
        .clk                         (clk),
        .ID_rst                      (ID_rst),
        .IF_ID_instruction           (IF_ID_instruction),
        .IF_ID_pc                    (IF_ID_pc),
        .IF_ID_branch_target_predict (IF_ID_branch_target_predict),
        .IF_ID_predictor             (IF_ID_predictor),
        .EX_ID_flush                 (EX_ID_flush),
        .WB_ID_reg_write             (WB_ID_reg_write),
        .WB_ID_write_reg             (WB_ID_write_reg),
        .WB_ID_write_data            (WB_ID_write_data),
        .ID_IF_jump                  (ID_IF_jump),
        .ID_IF_jump_target           (ID_IF_jump_target),
        .ID_IF_branch                (ID_IF_branch),
        .pc_enable                   (pc_enable),
        .IF_enable                   (IF_enable),
        .ID_EX_rs_data               (ID_EX_rs_data),
        .ID_EX_rt_data               (ID_EX_rt_data),
        .ID_EX_imm                   (ID_EX_imm),
        .ID_EX_rs                    (ID_EX_rs),
        .ID_EX_rt                    (ID_EX_rt),
        .ID_EX_rd                    (ID_EX_rd),
        .ID_EX_pc                    (ID_EX_pc),
        .ID_EX_branch_target_predict (ID_EX_branch_target_predict),
        .ID_EX_predictor             (ID_EX_predictor),
        .ID_EX_alu_op                (ID_EX_alu_op),
        .ID_EX_reg_write             (ID_EX_reg_write),
        .ID_EX_mem_read              (ID_EX_mem_read),
        .ID_EX_mem_write             (ID_EX_mem_write),
        .ID_EX_mem_to_reg            (ID_EX_mem_to_reg),
        .ID_EX_alu_src               (ID_EX_alu_src),
        .ID_EX_reg_dst               (ID_EX_reg_dst),
        .ID_EX_branch                (ID_EX_branch)
    );

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [VW-1:0] mk(input logic [6:0] ctl, input logic [2:0] alu,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [31:0] rsd,
                                         input logic [31:0] rtd, input logic [31:0] imm,
                                         input logic [31:0] pc, input logic [31:0] btp,
                                         input logic [1:0] pred);
        return {ctl, alu, rs, rt, rd, rsd, rtd, imm, pc, btp, pred};
    endfunction

    function automatic logic [VW-1:0] bubble();
        return mk(C_NONE, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 2'b01);
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] r_i(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic cmp_v(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic cmp_b(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are already set when this is called (just after a rising edge).
    task automatic step(input string tag, input logic [VW-1:0] e, input logic [VW-1:0] m,
                        input bit chk, input logic pe, input logic jmp, input logic br,
                        input logic [31:0] tgt);
        logic [VW-1:0] obs;
        logic [VW-1:0] want;
        exp_q.push_back(e);
        @(negedge clk);
        if (chk) begin
            cmp_b({tag, ".pc_enable"}, {31'd0, pc_enable}, {31'd0, pe});
            cmp_b({tag, ".IF_enable"}, {31'd0, IF_enable}, {31'd0, pe});
            cmp_b({tag, ".jump"},      {31'd0, ID_IF_jump}, {31'd0, jmp});
            cmp_b({tag, ".branch"},    {31'd0, ID_IF_branch}, {31'd0, br});
            if (jmp) cmp_b({tag, ".jump_target"}, ID_IF_jump_target, tgt);
        end
        @(posedge clk);
        #1;
        obs = {ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg,
               ID_EX_alu_src, ID_EX_reg_dst, ID_EX_branch, ID_EX_alu_op,
               ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm,
               ID_EX_pc, ID_EX_branch_target_predict, ID_EX_predictor};
        want = exp_q.pop_front();
        cmp_v({tag, ".id_ex"}, obs & m, want & m);
    endtask

    task automatic drive(input logic rst, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] btp, input logic [1:0] pred, input logic flush,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        ID_rst                      = rst;
        IF_ID_instruction           = instr;
        IF_ID_pc                    = pc;
        IF_ID_branch_target_predict = btp;
        IF_ID_predictor             = pred;
        EX_ID_flush                 = flush;
        WB_ID_reg_write             = we;
        WB_ID_write_reg             = wr;
        WB_ID_write_data            = wd;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] ins;
        logic [4:0]  kk;

        // reset; then write r7 and reset again while writing r8
        drive(1, 32'd0, 32'd0, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("reset", bubble(), FULL, 0, 1, 0, 0, 32'd0);
        drive(0, 32'd0, 32'd0, 32'd1, 2'b01, 0, 1, 5'd7, 32'hDEAD);
        step("wr_r7", bubble(), FULL, 1, 1, 0, 0, 32'd0);
        drive(1, 32'd0, 32'd0, 32'd1, 2'b01, 0, 1, 5'd8, 32'hBEEF);
        step("reset_mid_write", bubble(), FULL, 1, 1, 0, 0, 32'd0);

        // every register reads zero after reset
        for (int k = 1; k < 32; k++) begin
            kk  = 5'(k);
            ins = r_i(kk, kk, kk, 6'h20);
            drive(0, ins, 32'(k * 4), 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
            step($sformatf("zero_r%0d", k),
                 mk(C_R, 3'd0, kk, kk, kk, 32'd0, 32'd0, sext(ins[15:0]), 32'(k * 4), 32'd1, 2'b01),
                 FULL, 1, 1, 0, 0, 32'd0);
        end

        // write-through of r5 then stored value, r0 write ignored
        ins = r_i(5'd5, 5'd5, 5'd6, 6'h20);
        drive(0, ins, 32'h100, 32'h200, 2'b10, 0, 1, 5'd5, 32'h1234);
        step("wt_r5", mk(C_R, 3'd0, 5'd5, 5'd5, 5'd6, 32'h1234, 32'h1234, sext(ins[15:0]),
             32'h100, 32'h200, 2'b10), FULL, 1, 1, 0, 0, 32'd0);
        drive(0, ins, 32'h104, 32'h208, 2'b11, 0, 0, 5'd0, 32'd0);
        step("held_r5", mk(C_R, 3'd0, 5'd5, 5'd5, 5'd6, 32'h1234, 32'h1234, sext(ins[15:0]),
             32'h104, 32'h208, 2'b11), FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd0, 5'd0, 5'd6, 6'h20);
        drive(0, ins, 32'h108, 32'd1, 2'b01, 0, 1, 5'd0, 32'hFFFF);
        step("wr_r0", mk(C_R, 3'd0, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, sext(ins[15:0]),
             32'h108, 32'd1, 2'b01), FULL, 1, 1, 0, 0, 32'd0);

        // load-use on rs: lw r2,0(r1) ; add r3,r2,r4
        drive(0, 32'd0, 32'd0, 32'd1, 2'b01, 0, 1, 5'd1, 32'h10);
        step("wr_r1", bubble(), FULL, 1, 1, 0, 0, 32'd0);
        drive(0, i_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h200, 32'd1, 2'b01, 0, 1, 5'd4, 32'h44);
        step("lw_a", mk(C_LW, 3'd0, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd0, 32'h200, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd2, 5'd4, 5'd3, 6'h20);
        drive(0, ins, 32'h204, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lu_stall_add", bubble(), FULL, 1, 0, 0, 0, 32'd0);
        step("lu_issue_add", mk(C_R, 3'd0, 5'd2, 5'd4, 5'd3, 32'd0, 32'h44, 32'h1820,
             32'h204, 32'd1, 2'b01), FULL, 1, 1, 0, 0, 32'd0);

        // load-use on rt of sw
        drive(0, i_i(6'h23, 5'd1, 5'd2, 16'h8), 32'h300, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lw_b", mk(C_LW, 3'd0, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd8, 32'h300, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        drive(0, i_i(6'h2B, 5'd3, 5'd2, 16'h4), 32'h304, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lu_stall_sw", bubble(), FULL, 1, 0, 0, 0, 32'd0);
        step("lu_issue_sw", mk(C_SW, 3'd0, 5'd3, 5'd2, 5'd0, 32'd0, 32'd0, 32'd4, 32'h304, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);

        // rt match on addi is not a hazard
        drive(0, i_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h310, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lw_c", mk(C_LW, 3'd0, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd0, 32'h310, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        drive(0, i_i(6'h08, 5'd4, 5'd2, 16'h7), 32'h314, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("addi_rt_nohaz", mk(C_ADDI, 3'd0, 5'd4, 5'd2, 5'd0, 32'h44, 32'd0, 32'd7, 32'h314, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);

        // lw to r0 never stalls
        drive(0, i_i(6'h23, 5'd1, 5'd0, 16'h0), 32'h320, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lw_r0", mk(C_LW, 3'd0, 5'd1, 5'd0, 5'd0, 32'h10, 32'd0, 32'd0, 32'h320, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd0, 5'd0, 5'd3, 6'h20);
        drive(0, ins, 32'h324, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("r0_nohaz", mk(C_R, 3'd0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h1820, 32'h324, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);

        // jump, then a jump suppressed by a stall
        drive(0, {6'h02, 26'h0000010}, 32'h40000004, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("jump", bubble(), CTRL_M, 1, 1, 1, 0, 32'h40000040);
        drive(0, i_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h400, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lw_d", mk(C_LW, 3'd0, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd0, 32'h400, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        drive(0, {6'h02, 26'h0400000}, 32'h40000004, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("jump_stalled", bubble(), FULL, 1, 0, 0, 0, 32'd0);
        step("jump_after_stall", bubble(), CTRL_M, 1, 1, 1, 0, 32'h41000000);

        // flush with beq in ID, then beq normally, then negative addi
        ins = i_i(6'h04, 5'd1, 5'd2, 16'h3);
        drive(0, ins, 32'h500, 32'hABC, 2'b11, 1, 0, 5'd0, 32'd0);
        step("flush_beq", bubble(), FULL, 1, 1, 0, 1, 32'd0);
        drive(0, ins, 32'h500, 32'hABC, 2'b11, 0, 0, 5'd0, 32'd0);
        step("beq", mk(C_BEQ, 3'd1, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd3, 32'h500, 32'hABC, 2'b11),
             FULL, 1, 1, 0, 1, 32'd0);
        drive(0, i_i(6'h08, 5'd1, 5'd9, 16'hFFFF), 32'h504, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("addi_neg", mk(C_ADDI, 3'd0, 5'd1, 5'd9, 5'd31, 32'h10, 32'd0, 32'hFFFFFFFF,
             32'h504, 32'd1, 2'b01), FULL, 1, 1, 0, 0, 32'd0);

        // remaining ALU functions and an unlisted funct
        ins = r_i(5'd4, 5'd1, 5'd3, 6'h22);
        drive(0, ins, 32'h600, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("sub", mk(C_R, 3'd1, 5'd4, 5'd1, 5'd3, 32'h44, 32'h10, 32'h1822, 32'h600, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd4, 5'd1, 5'd3, 6'h24);
        drive(0, ins, 32'h604, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("and", mk(C_R, 3'd2, 5'd4, 5'd1, 5'd3, 32'h44, 32'h10, 32'h1824, 32'h604, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd4, 5'd1, 5'd3, 6'h25);
        drive(0, ins, 32'h608, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("or", mk(C_R, 3'd3, 5'd4, 5'd1, 5'd3, 32'h44, 32'h10, 32'h1825, 32'h608, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd4, 5'd1, 5'd3, 6'h2A);
        drive(0, ins, 32'h60C, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("slt", mk(C_R, 3'd4, 5'd4, 5'd1, 5'd3, 32'h44, 32'h10, 32'h182A, 32'h60C, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd4, 5'd1, 5'd3, 6'h21);
        drive(0, ins, 32'h610, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("bad_funct", mk(C_NONE, 3'd0, 5'd4, 5'd1, 5'd3, 32'h44, 32'h10, 32'h1821,
             32'h610, 32'd1, 2'b01), CTRL_M, 1, 1, 0, 0, 32'd0);
        drive(0, i_i(6'h0D, 5'd1, 5'd3, 16'h5), 32'h614, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("bad_op", bubble(), CTRL_M, 1, 1, 0, 0, 32'd0);

        // flush coinciding with a load-use stall still holds fetch
        drive(0, i_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h700, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lw_e", mk(C_LW, 3'd0, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd0, 32'h700, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        ins = r_i(5'd2, 5'd4, 5'd3, 6'h20);
        drive(0, ins, 32'h704, 32'd1, 2'b01, 1, 0, 5'd0, 32'd0);
        step("flush_and_stall", bubble(), FULL, 1, 0, 0, 0, 32'd0);
        drive(0, ins, 32'h704, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("after_flush", mk(C_R, 3'd0, 5'd2, 5'd4, 5'd3, 32'd0, 32'h44, 32'h1820, 32'h704, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);

        // reset during a stall: stall dropped, registers cleared
        drive(0, i_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h800, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("lw_f", mk(C_LW, 3'd0, 5'd1, 5'd2, 5'd0, 32'h10, 32'd0, 32'd0, 32'h800, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);
        drive(1, ins, 32'h804, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("reset_mid_stall", bubble(), FULL, 0, 0, 0, 0, 32'd0);
        drive(0, ins, 32'h804, 32'd1, 2'b01, 0, 0, 5'd0, 32'd0);
        step("post_reset_add", mk(C_R, 3'd0, 5'd2, 5'd4, 5'd3, 32'd0, 32'd0, 32'h1820, 32'h804, 32'd1, 2'b01),
             FULL, 1, 1, 0, 0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
